fifo_stream_reader: RTL and testbench



---
 rtl/fifo_stream_reader.sv | 149 ++++++++++++++
 tb/tb_fifo_stream_reader.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// Purpose : read-side master that pops `len` words from a synchronous FIFO and streams them out.
// Latency : first word on m_data 3 cycles after start (1 to enter RUN, 1 FIFO read, 1 into skid).
// Backpr. : 2-entry skid buffer; reads are issued only when a slot is guaranteed, 1 word/clk sustained.
//
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   start, len                 transfer request (sampled in IDLE) and word count
//   busy, done                 transfer in progress / one-cycle completion pulse
//   fifo_rd, fifo_empty,       FIFO read strobe, empty flag, and read data
//   fifo_dout                  (read data valid the cycle after fifo_rd)
//   m_valid, m_data, m_ready   output stream, valid/ready handshake
//   issued_cnt                 reads issued in the current transfer
module fifo_stream_reader #(
  parameter int DW = 8,
  parameter int LW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [LW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic          fifo_rd,
  input  logic          fifo_empty,
  input  logic [DW-1:0] fifo_dout,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  input  logic          m_ready,
  output logic [LW-1:0] issued_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_e;

  state_e        state_q;
  logic [LW-1:0] len_q;
  logic [LW-1:0] issued_cnt_q;
  logic          inflight_q;   // a read was issued last cycle; fifo_dout is valid now
  logic [1:0]    cnt_q;        // skid buffer occupancy (0..2)
  logic [DW-1:0] buf0_q;       // head entry, drives m_data
  logic [DW-1:0] buf1_q;
  logic          busy_q;
  logic          done_q;

  logic [1:0]    cnt_d;
  logic [DW-1:0] buf0_d;
  logic [DW-1:0] buf1_d;
  logic          pop;
  logic          push;
  logic [1:0]    occ;
  logic          drained;

  always_comb begin
    pop  = (cnt_q != 2'd0) & m_ready;
    push = inflight_q;
    // Words already committed to the buffer: stored plus the one arriving from the FIFO.
    occ  = cnt_q + {1'b0, inflight_q};
    // m_ready feeds fifo_rd directly: a pop this cycle frees the slot the new read will need.
    fifo_rd = (state_q == S_RUN) & ~fifo_empty & (issued_cnt_q < len_q)
            & ((occ < 2'd2) | pop);
    // The buffer is empty after this edge: nothing in flight and the last word (if any) leaves now.
    // Testing this one cycle early lets done land the cycle right after the final acceptance.
    drained = ~inflight_q & ((cnt_q == 2'd0) | ((cnt_q == 2'd1) & pop));
  end

  // Skid buffer next state, FIFO order with buf0 as head.
  always_comb begin
    cnt_d  = cnt_q;
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) buf0_d = fifo_dout;
        else               buf1_d = fifo_dout;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        buf0_d = buf1_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          buf0_d = fifo_dout;
        end else begin
          buf0_d = buf1_q;
          buf1_d = fifo_dout;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      issued_cnt_q <= '0;
      inflight_q   <= 1'b0;
      cnt_q        <= 2'd0;
      buf0_q       <= '0;
      buf1_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      inflight_q <= fifo_rd;
      cnt_q      <= cnt_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      done_q     <= 1'b0;
      if (fifo_rd) issued_cnt_q <= issued_cnt_q + 1'b1;

      case (state_q)
        S_IDLE: begin
          if (start) begin
            len_q        <= len;
            issued_cnt_q <= '0;
            busy_q       <= 1'b1;
            if (len == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (issued_cnt_q == len_q) state_q <= S_FLUSH;
        end
        S_FLUSH: begin
          if (drained) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign m_valid    = (cnt_q != 2'd0);
  assign m_data     = buf0_q;
  assign issued_cnt = issued_cnt_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Purpose : directed bench for fifo_stream_reader with a behavioural byte FIFO and a stream scoreboard.
// Latency : FIFO model returns data one cycle after a read, matching the real FIFO.
// Backpr. : m_ready is driven per test; the monitor checks data order and hold under stall.
module tb_fifo_stream_reader;
  localparam int DW = 8;
  localparam int LW = 8;

  logic          clk        = 1'b0;
  logic          rst_n      = 1'b0;
  logic          start      = 1'b0;
  logic [LW-1:0] len        = '0;
  logic          busy;
  logic          done;
  logic          fifo_rd;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_dout  = '0;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready    = 1'b0;
  logic [LW-1:0] issued_cnt;

  fifo_stream_reader #(.DW(DW), .LW(LW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .fifo_rd    (fifo_rd),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready),
    .issued_cnt (issued_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural synchronous FIFO: registered empty flag, one-cycle read latency.
  logic          fw_en  = 1'b0;
  logic [DW-1:0] fw_dat = '0;
  logic [DW-1:0] fq[$];
  int            underflows = 0;

  always @(posedge clk) begin
    if (fifo_rd) begin
      if (fq.size() == 0) underflows <= underflows + 1;
      else                fifo_dout  <= fq.pop_front();
    end
    if (fw_en) fq.push_back(fw_dat);
    fifo_empty <= (fq.size() == 0);
  end

  // Scoreboard and bookkeeping.
  logic [DW-1:0] exp_q[$];
  int n_chk  = 0;
  int n_fail = 0;
  int rd_cnt = 0;
  int acc_cnt = 0;
  int done_cnt = 0;
  logic          hold_q   = 1'b0;
  logic [DW-1:0] hold_dat = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_q <= 1'b0;
    end else begin
      if (fifo_rd) begin
        rd_cnt <= rd_cnt + 1;
        chk("rd_while_empty", 32'(fifo_empty), 32'd0);
      end
      if (done) done_cnt <= done_cnt + 1;
      if (m_valid && hold_q) chk("m_data_hold", 32'(m_data), 32'(hold_dat));
      if (m_valid && m_ready) begin
        acc_cnt <= acc_cnt + 1;
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL extra_word: got 0x%0h with no word expected at %0t", m_data, $time);
        end else begin
          chk("stream_data", 32'(m_data), 32'(exp_q.pop_front()));
        end
      end
      hold_q   <= m_valid && !m_ready;
      hold_dat <= m_data;
    end
  end

  task automatic push_word(input logic [DW-1:0] d);
    @(posedge clk); #1;
    fw_en  = 1'b1;
    fw_dat = d;
    @(posedge clk); #1;
    fw_en  = 1'b0;
  endtask

  // Leaves the bench 1 ns into the cycle after start; len is then scrambled.
  task automatic pulse_start(input logic [LW-1:0] l);
    @(posedge clk); #1;
    start = 1'b1;
    len   = l;
    @(posedge clk); #1;
    start = 1'b0;
    len   = 8'hEE;
  endtask

  task automatic wait_done(input int budget);
    int base = done_cnt;
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk); #1;
      if (done_cnt != base) seen = 1'b1;
    end
    chk("done_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int rb, ab, db;

  initial begin
    // Reset state.
    #12;
    chk("rst_busy",       32'(busy),       32'd0);
    chk("rst_done",       32'(done),       32'd0);
    chk("rst_fifo_rd",    32'(fifo_rd),    32'd0);
    chk("rst_m_valid",    32'(m_valid),    32'd0);
    chk("rst_m_data",     32'(m_data),     32'd0);
    chk("rst_issued_cnt", 32'(issued_cnt), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Throughput: 4 words at full rate.
    for (int i = 0; i < 4; i++) push_word(DW'(8'h10 + i));
    for (int i = 0; i < 4; i++) exp_q.push_back(DW'(8'h10 + i));
    m_ready = 1'b1;
    rb = rd_cnt; ab = acc_cnt;
    pulse_start(8'd4);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("tp_fifo_rd", 32'(fifo_rd), 32'(k >= 1 && k <= 4));
      chk("tp_m_valid", 32'(m_valid), 32'(k >= 3 && k <= 6));
      chk("tp_done",    32'(done),    32'(k == 7));
      chk("tp_busy",    32'(busy),    32'(k <= 7));
      if (k == 5) chk("tp_issued_cnt", 32'(issued_cnt), 32'd4);
    end
    #1;
    chk("tp_rd_total",  32'(rd_cnt - rb),  32'd4);
    chk("tp_acc_total", 32'(acc_cnt - ab), 32'd4);
    chk("tp_sb_empty",  32'(exp_q.size()), 32'd0);

    // Backpressure: consumer stalled for 10 cycles.
    for (int i = 0; i < 6; i++) push_word(DW'(8'h20 + i));
    for (int i = 0; i < 6; i++) exp_q.push_back(DW'(8'h20 + i));
    m_ready = 1'b0;
    rb = rd_cnt; ab = acc_cnt;
    pulse_start(8'd6);
    repeat (10) @(negedge clk);
    #1;
    chk("bp_rd_during_stall", 32'(rd_cnt - rb), 32'd2);
    chk("bp_m_valid",         32'(m_valid),     32'd1);
    chk("bp_m_data_head",     32'(m_data),      32'h20);
    chk("bp_issued_cnt",      32'(issued_cnt),  32'd2);
    @(posedge clk); #1;
    m_ready = 1'b1;
    wait_done(100);
    chk("bp_acc_total", 32'(acc_cnt - ab), 32'd6);
    chk("bp_rd_total",  32'(rd_cnt - rb),  32'd6);
    chk("bp_sb_empty",  32'(exp_q.size()), 32'd0);

    // Empty gaps: writer trickles words in while the transfer runs.
    for (int i = 0; i < 5; i++) exp_q.push_back(DW'(8'hA0 + i));
    rb = rd_cnt; ab = acc_cnt; db = done_cnt;
    pulse_start(8'd5);
    for (int i = 0; i < 5; i++) begin
      push_word(DW'(8'hA0 + i));
      @(posedge clk);
    end
    wait_done(100);
    chk("gap_acc_total", 32'(acc_cnt - ab),  32'd5);
    chk("gap_rd_total",  32'(rd_cnt - rb),   32'd5);
    chk("gap_done_cnt",  32'(done_cnt - db), 32'd1);
    chk("gap_sb_empty",  32'(exp_q.size()),  32'd0);
    chk("gap_empty_err", 32'(underflows),    32'd0);

    // Zero length with a word waiting in the FIFO.
    push_word(8'h30);
    rb = rd_cnt; db = done_cnt;
    pulse_start(8'd0);
    chk("zl_done",       32'(done),       32'd1);
    chk("zl_busy",       32'(busy),       32'd1);
    chk("zl_issued_cnt", 32'(issued_cnt), 32'd0);
    chk("zl_fifo_rd",    32'(fifo_rd),    32'd0);
    @(posedge clk); #1;
    chk("zl_done_low", 32'(done), 32'd0);
    chk("zl_busy_low", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("zl_rd_total", 32'(rd_cnt - rb),   32'd0);
    chk("zl_done_cnt", 32'(done_cnt - db), 32'd1);

    // Start while busy is ignored.
    push_word(8'h31);
    push_word(8'h32);
    push_word(8'h33);
    exp_q.push_back(8'h30);
    exp_q.push_back(8'h31);
    exp_q.push_back(8'h32);
    rb = rd_cnt; ab = acc_cnt; db = done_cnt;
    pulse_start(8'd3);
    @(posedge clk); #1;
    start = 1'b1;
    len   = 8'd9;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(100);
    chk("sb_issued_cnt", 32'(issued_cnt), 32'd3);
    repeat (6) @(posedge clk);
    #1;
    chk("sb_rd_total",  32'(rd_cnt - rb),   32'd3);
    chk("sb_acc_total", 32'(acc_cnt - ab),  32'd3);
    chk("sb_done_cnt",  32'(done_cnt - db), 32'd1);
    chk("sb_sb_empty",  32'(exp_q.size()),  32'd0);
    chk("sb_busy_low",  32'(busy),          32'd0);

    // Reset mid-transfer after 2 of 5 words, then a fresh 3-word transfer.
    for (int i = 0; i < 6; i++) push_word(DW'(8'h41 + i));
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h41);
    ab = acc_cnt;
    pulse_start(8'd5);
    begin
      bit got2 = 1'b0;
      for (int i = 0; i < 50 && !got2; i++) begin
        @(negedge clk); #1;
        if (acc_cnt - ab >= 2) got2 = 1'b1;
      end
      chk("rm_two_words_seen", 32'(got2), 32'd1);
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rm_busy",       32'(busy),       32'd0);
    chk("rm_done",       32'(done),       32'd0);
    chk("rm_m_valid",    32'(m_valid),    32'd0);
    chk("rm_fifo_rd",    32'(fifo_rd),    32'd0);
    chk("rm_m_data",     32'(m_data),     32'd0);
    chk("rm_issued_cnt", 32'(issued_cnt), 32'd0);
    #9;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rm_idle_after", 32'(busy),          32'd0);
    chk("rm_sb_empty",   32'(exp_q.size()),  32'd0);
    exp_q.push_back(8'h44);
    exp_q.push_back(8'h45);
    exp_q.push_back(8'h46);
    ab = acc_cnt;
    pulse_start(8'd3);
    wait_done(100);
    chk("rm2_acc_total",  32'(acc_cnt - ab), 32'd3);
    chk("rm2_sb_empty",   32'(exp_q.size()), 32'd0);
    chk("rm2_fifo_left",  32'(fq.size()),    32'd0);
    chk("final_empty_err", 32'(underflows),  32'd0);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
